// File: rtl/frv_rvfi_trace.sv
// frv_rvfi_trace: registers one RVFI trace record per retired instruction.
// It numbers the records and tracks trap/handler-entry/halt state.
// Optional feature macro: RVFI_WIDE_WRITEBACK_EN traces 64-bit register-pair
// writebacks. When it is undefined, rvfi_rd_wide and rvfi_rd_wdatahi stay zero.
module frv_rvfi_trace #(
  parameter int unsigned XLEN = 32
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              ret_valid,
  input  logic [31:0]       ret_insn,
  input  logic [XLEN-1:0]   ret_pc,
  input  logic [XLEN-1:0]   ret_npc,
  input  logic              ret_trap,
  input  logic [4:0]        ret_rs1_addr,
  input  logic [4:0]        ret_rs2_addr,
  input  logic [4:0]        ret_rs3_addr,
  input  logic [4:0]        ret_rd_addr,
  input  logic [XLEN-1:0]   ret_rs1_data,
  input  logic [XLEN-1:0]   ret_rs2_data,
  input  logic [XLEN-1:0]   ret_rs3_data,
  input  logic [XLEN-1:0]   ret_rd_data,
  input  logic              ret_rd_wide,
  input  logic [XLEN-1:0]   ret_rd_datahi,
  input  logic [XLEN-1:0]   ret_mem_addr,
  input  logic [XLEN-1:0]   ret_mem_wdata,
  input  logic [XLEN-1:0]   ret_mem_rdata,
  input  logic [XLEN/8-1:0] ret_mem_rmask,
  input  logic [XLEN/8-1:0] ret_mem_wmask,
  input  logic              ret_halt,
  output logic              rvfi_valid,
  output logic [63:0]       rvfi_order,
  output logic [31:0]       rvfi_insn,
  output logic              rvfi_trap,
  output logic              rvfi_halt,
  output logic              rvfi_intr,
  output logic [XLEN-1:0]   rvfi_pc_rdata,
  output logic [XLEN-1:0]   rvfi_pc_wdata,
  output logic [4:0]        rvfi_rs1_addr,
  output logic [4:0]        rvfi_rs2_addr,
  output logic [4:0]        rvfi_rs3_addr,
  output logic [XLEN-1:0]   rvfi_rs1_rdata,
  output logic [XLEN-1:0]   rvfi_rs2_rdata,
  output logic [XLEN-1:0]   rvfi_rs3_rdata,
  output logic [4:0]        rvfi_rd_addr,
  output logic [XLEN-1:0]   rvfi_rd_wdata,
  output logic              rvfi_rd_wide,
  output logic [XLEN-1:0]   rvfi_rd_wdatahi,
  output logic [XLEN-1:0]   rvfi_mem_addr,
  output logic [XLEN/8-1:0] rvfi_mem_rmask,
  output logic [XLEN/8-1:0] rvfi_mem_wmask,
  output logic [XLEN-1:0]   rvfi_mem_rdata,
  output logic [XLEN-1:0]   rvfi_mem_wdata
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_TRAPPED,
    ST_HALTED
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_fire;
  logic [63:0]       r_order;
  logic [XLEN-1:0]   w_rd_wdata;
  logic [XLEN-1:0]   w_rd_wdatahi;
  logic              w_rd_wide;

  // Decide whether this retirement is accepted, and compute the next trace state.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = ret_valid && (r_state != ST_HALTED);
    if (w_fire) begin
      if (ret_halt)      w_state_nxt = ST_HALTED;
      else if (ret_trap) w_state_nxt = ST_TRAPPED;
      else               w_state_nxt = ST_RUN;
    end
  end

  // Writeback value: x0 and trapping instructions never report a register write.
  always_comb begin
    w_rd_wdata = ((ret_rd_addr == 5'd0) || ret_trap) ? '0 : ret_rd_data;
  end

`ifdef RVFI_WIDE_WRITEBACK_EN
  // High writeback word is reported only for a wide write to a real register.
  always_comb begin
    w_rd_wide    = ret_rd_wide;
    w_rd_wdatahi = (ret_rd_wide && (ret_rd_addr != 5'd0)) ? ret_rd_datahi : '0;
  end
`else
  logic w_unused_wide;

  // Wide writeback is not traced in this build.
  always_comb begin
    w_rd_wide     = 1'b0;
    w_rd_wdatahi  = '0;
    w_unused_wide = ret_rd_wide ^ (^ret_rd_datahi);
  end
`endif

  // State register and record counter.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state <= ST_RUN;
      r_order <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fire) r_order <= r_order + 64'd1;
    end
  end

  // Trace record register: fields update only on an accepted retirement and hold otherwise.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rvfi_valid      <= 1'b0;
      rvfi_order      <= '0;
      rvfi_insn       <= '0;
      rvfi_trap       <= 1'b0;
      rvfi_halt       <= 1'b0;
      rvfi_intr       <= 1'b0;
      rvfi_pc_rdata   <= '0;
      rvfi_pc_wdata   <= '0;
      rvfi_rs1_addr   <= '0;
      rvfi_rs2_addr   <= '0;
      rvfi_rs3_addr   <= '0;
      rvfi_rs1_rdata  <= '0;
      rvfi_rs2_rdata  <= '0;
      rvfi_rs3_rdata  <= '0;
      rvfi_rd_addr    <= '0;
      rvfi_rd_wdata   <= '0;
      rvfi_rd_wide    <= 1'b0;
      rvfi_rd_wdatahi <= '0;
      rvfi_mem_addr   <= '0;
      rvfi_mem_rmask  <= '0;
      rvfi_mem_wmask  <= '0;
      rvfi_mem_rdata  <= '0;
      rvfi_mem_wdata  <= '0;
    end else begin
      rvfi_valid <= w_fire;
      if (w_fire) begin
        rvfi_order      <= r_order;
        rvfi_insn       <= ret_insn;
        rvfi_trap       <= ret_trap;
        rvfi_halt       <= ret_halt;
        rvfi_intr       <= (r_state == ST_TRAPPED);
        rvfi_pc_rdata   <= ret_pc;
        rvfi_pc_wdata   <= ret_npc;
        rvfi_rs1_addr   <= ret_rs1_addr;
        rvfi_rs2_addr   <= ret_rs2_addr;
        rvfi_rs3_addr   <= ret_rs3_addr;
        rvfi_rs1_rdata  <= ret_rs1_data;
        rvfi_rs2_rdata  <= ret_rs2_data;
        rvfi_rs3_rdata  <= ret_rs3_data;
        rvfi_rd_addr    <= ret_trap ? 5'd0 : ret_rd_addr;
        rvfi_rd_wdata   <= w_rd_wdata;
        rvfi_rd_wide    <= w_rd_wide;
        rvfi_rd_wdatahi <= w_rd_wdatahi;
        rvfi_mem_addr   <= ret_mem_addr;
        rvfi_mem_rmask  <= ret_trap ? '0 : ret_mem_rmask;
        rvfi_mem_wmask  <= ret_trap ? '0 : ret_mem_wmask;
        rvfi_mem_rdata  <= ret_mem_rdata;
        rvfi_mem_wdata  <= ret_mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_frv_rvfi_trace.sv
// Self-checking bench for frv_rvfi_trace.
// A behavioural reference model predicts each trace record from the retirement inputs.
// Honours RVFI_WIDE_WRITEBACK_EN in the same way as the design.
module tb_frv_rvfi_trace;
  localparam int unsigned XLEN = 32;
  localparam int unsigned MW   = XLEN / 8;
  localparam int unsigned OBSW = 121 + 10 * XLEN + 2 * MW;

  logic g_clk = 1'b0;
  logic g_resetn;
  logic ret_valid, ret_trap, ret_halt, ret_rd_wide;
  logic [31:0] ret_insn;
  logic [XLEN-1:0] ret_pc, ret_npc, ret_rs1_data, ret_rs2_data, ret_rs3_data;
  logic [XLEN-1:0] ret_rd_data, ret_rd_datahi, ret_mem_addr, ret_mem_wdata, ret_mem_rdata;
  logic [4:0] ret_rs1_addr, ret_rs2_addr, ret_rs3_addr, ret_rd_addr;
  logic [MW-1:0] ret_mem_rmask, ret_mem_wmask;

  logic rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rd_wide;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [XLEN-1:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
  logic [XLEN-1:0] rvfi_rd_wdata, rvfi_rd_wdatahi, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [4:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr, rvfi_rd_addr;
  logic [MW-1:0] rvfi_mem_rmask, rvfi_mem_wmask;

  // Expected record fields produced by the model
  logic e_valid, e_trap, e_halt, e_intr, e_rd_wide;
  logic [63:0] e_order;
  logic [31:0] e_insn;
  logic [XLEN-1:0] e_pc_rdata, e_pc_wdata, e_rs1_rdata, e_rs2_rdata, e_rs3_rdata;
  logic [XLEN-1:0] e_rd_wdata, e_rd_wdatahi, e_mem_addr, e_mem_rdata, e_mem_wdata;
  logic [4:0] e_rs1_addr, e_rs2_addr, e_rs3_addr, e_rd_addr;
  logic [MW-1:0] e_mem_rmask, e_mem_wmask;

  // Model state: records emitted so far, whether the last record trapped, halted flag
  logic [63:0] m_count;
  logic m_after_trap, m_halted;

  int vectors = 0;
  int miscompares = 0;

  logic [OBSW-1:0] w_obs, w_exp;
  assign w_obs = {rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
                  rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr,
                  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata, rvfi_rd_addr, rvfi_rd_wdata,
                  rvfi_rd_wide, rvfi_rd_wdatahi, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
                  rvfi_mem_rdata, rvfi_mem_wdata};
  assign w_exp = {e_valid, e_order, e_insn, e_trap, e_halt, e_intr,
                  e_pc_rdata, e_pc_wdata, e_rs1_addr, e_rs2_addr, e_rs3_addr,
                  e_rs1_rdata, e_rs2_rdata, e_rs3_rdata, e_rd_addr, e_rd_wdata,
                  e_rd_wide, e_rd_wdatahi, e_mem_addr, e_mem_rmask, e_mem_wmask,
                  e_mem_rdata, e_mem_wdata};

  frv_rvfi_trace #(.XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .ret_valid(ret_valid), .ret_insn(ret_insn),
    .ret_pc(ret_pc), .ret_npc(ret_npc), .ret_trap(ret_trap),
    .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr), .ret_rs3_addr(ret_rs3_addr),
    .ret_rd_addr(ret_rd_addr), .ret_rs1_data(ret_rs1_data), .ret_rs2_data(ret_rs2_data),
    .ret_rs3_data(ret_rs3_data), .ret_rd_data(ret_rd_data), .ret_rd_wide(ret_rd_wide),
    .ret_rd_datahi(ret_rd_datahi), .ret_mem_addr(ret_mem_addr), .ret_mem_wdata(ret_mem_wdata),
    .ret_mem_rdata(ret_mem_rdata), .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
    .ret_halt(ret_halt),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_rd_wide(rvfi_rd_wide),
    .rvfi_rd_wdatahi(rvfi_rd_wdatahi), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata)
  );

  always #5 g_clk = ~g_clk;

  // Randomise every retirement field; valid/trap/halt are chosen by the caller
  task automatic rnd(input logic v, input logic t, input logic h);
    ret_valid     = v;
    ret_trap      = t;
    ret_halt      = h;
    ret_insn      = $urandom;
    ret_pc        = XLEN'($urandom);
    ret_npc       = XLEN'($urandom);
    ret_rs1_addr  = 5'($urandom);
    ret_rs2_addr  = 5'($urandom);
    ret_rs3_addr  = 5'($urandom);
    ret_rd_addr   = 5'($urandom);
    ret_rs1_data  = XLEN'($urandom);
    ret_rs2_data  = XLEN'($urandom);
    ret_rs3_data  = XLEN'($urandom);
    ret_rd_data   = XLEN'($urandom);
    ret_rd_wide   = 1'($urandom);
    ret_rd_datahi = XLEN'($urandom);
    ret_mem_addr  = XLEN'($urandom);
    ret_mem_wdata = XLEN'($urandom);
    ret_mem_rdata = XLEN'($urandom);
    ret_mem_rmask = MW'($urandom);
    ret_mem_wmask = MW'($urandom);
  endtask

  // Clock edge: the model consumes the same inputs as the DUT, then outputs settle
  task automatic tick();
    @(posedge g_clk);
    if (!g_resetn) begin
      {e_valid, e_order, e_insn, e_trap, e_halt, e_intr, e_pc_rdata, e_pc_wdata,
       e_rs1_addr, e_rs2_addr, e_rs3_addr, e_rs1_rdata, e_rs2_rdata, e_rs3_rdata,
       e_rd_addr, e_rd_wdata, e_rd_wide, e_rd_wdatahi, e_mem_addr, e_mem_rmask,
       e_mem_wmask, e_mem_rdata, e_mem_wdata} = '0;
      m_count = '0;
      m_after_trap = 1'b0;
      m_halted = 1'b0;
    end else if (ret_valid && !m_halted) begin
      e_valid     = 1'b1;
      e_order     = m_count;
      m_count     = m_count + 64'd1;
      e_insn      = ret_insn;
      e_trap      = ret_trap;
      e_halt      = ret_halt;
      e_intr      = m_after_trap;
      e_pc_rdata  = ret_pc;
      e_pc_wdata  = ret_npc;
      e_rs1_addr  = ret_rs1_addr;
      e_rs2_addr  = ret_rs2_addr;
      e_rs3_addr  = ret_rs3_addr;
      e_rs1_rdata = ret_rs1_data;
      e_rs2_rdata = ret_rs2_data;
      e_rs3_rdata = ret_rs3_data;
      e_rd_addr   = ret_trap ? 5'd0 : ret_rd_addr;
      e_rd_wdata  = (ret_trap || ret_rd_addr == 5'd0) ? '0 : ret_rd_data;
`ifdef RVFI_WIDE_WRITEBACK_EN
      e_rd_wide    = ret_rd_wide;
      e_rd_wdatahi = (ret_rd_wide && ret_rd_addr != 5'd0) ? ret_rd_datahi : '0;
`else
      e_rd_wide    = 1'b0;
      e_rd_wdatahi = '0;
`endif
      e_mem_addr  = ret_mem_addr;
      e_mem_rmask = ret_trap ? '0 : ret_mem_rmask;
      e_mem_wmask = ret_trap ? '0 : ret_mem_wmask;
      e_mem_rdata = ret_mem_rdata;
      e_mem_wdata = ret_mem_wdata;
      m_after_trap = ret_trap;
      if (ret_halt) m_halted = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    rnd(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    vectors++;
    if (w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL reset_record: got %h expected %h", w_obs, w_exp);
    end
    vectors++;
    if ({rvfi_valid, rvfi_order} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_valid_order: got %b/%0d expected 0/0", rvfi_valid, rvfi_order);
    end
    g_resetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      rnd(1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL b2b_record%0d: got %h expected %h", i, w_obs, w_exp);
      end
      vectors++;
      if (rvfi_valid !== 1'b1 || rvfi_order !== 64'(i)) begin
        miscompares++;
        $display("FAIL b2b_order%0d: got %b/%0d expected 1/%0d", i, rvfi_valid, rvfi_order, i);
      end
    end
    rnd(1'b0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL idle_hold: got %h expected %h", w_obs, w_exp);
    end
  endtask

  task automatic test_rd_zero();
    for (int i = 0; i < 2; i++) begin
      rnd(1'b1, 1'b0, 1'b0);
      ret_rd_addr = (i == 0) ? 5'd0 : 5'd5;
      ret_rd_data = 32'hDEADBEEF;
      tick();
      vectors++;
      if (rvfi_rd_wdata !== ((i == 0) ? 32'h0 : 32'hDEADBEEF)) begin
        miscompares++;
        $display("FAIL rd_wdata_rd%0d: got %h expected %h", ret_rd_addr, rvfi_rd_wdata,
                 (i == 0) ? 32'h0 : 32'hDEADBEEF);
      end
      vectors++;
      if (w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL rd_record%0d: got %h expected %h", i, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_trap_intr();
    rnd(1'b1, 1'b1, 1'b0);
    ret_mem_wmask = 4'hF;
    ret_rd_addr = 5'd7;
    tick();
    vectors++;
    if ({rvfi_trap, rvfi_mem_wmask, rvfi_rd_addr, rvfi_rd_wdata} !== {1'b1, 4'h0, 5'd0, 32'h0}) begin
      miscompares++;
      $display("FAIL trap_fields: got trap=%b wmask=%h rd=%0d wdata=%h expected 1/0/0/0",
               rvfi_trap, rvfi_mem_wmask, rvfi_rd_addr, rvfi_rd_wdata);
    end
    for (int i = 0; i < 2; i++) begin
      rnd(1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (rvfi_intr !== ((i == 0) ? 1'b1 : 1'b0) || w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL intr_step%0d: got intr=%b rec=%h expected intr=%b rec=%h",
                 i, rvfi_intr, w_obs, (i == 0), w_exp);
      end
    end
  endtask

  task automatic test_wrap();
    force dut.r_order = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_order;
    m_count = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      rnd(1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (rvfi_order !== ((i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0) || w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL wrap_order%0d: got %h expected %h", i, rvfi_order, e_order);
      end
    end
  endtask

  task automatic test_wide();
    logic [XLEN-1:0] want;
`ifdef RVFI_WIDE_WRITEBACK_EN
    want = 32'h12345678;
`else
    want = '0;
`endif
    rnd(1'b1, 1'b0, 1'b0);
    ret_rd_wide = 1'b1;
    ret_rd_addr = 5'd6;
    ret_rd_datahi = 32'h12345678;
    tick();
    vectors++;
    if (rvfi_rd_wdatahi !== want || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL wide_hi: got %h expected %h", rvfi_rd_wdatahi, want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rnd(($urandom_range(9, 0) < 7), ($urandom_range(9, 0) < 2), 1'b0);
      tick();
      vectors++;
      if (w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL random%0d: got %h expected %h", i, w_obs, w_exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rnd(1'b1, 1'b1, 1'b0);
    tick();
    g_resetn = 1'b0;
    rnd(1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (rvfi_valid !== 1'b0 || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL midreset_discard: got %h expected %h", w_obs, w_exp);
    end
    g_resetn = 1'b1;
    rnd(1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if ({rvfi_valid, rvfi_order, rvfi_intr} !== {1'b1, 64'd0, 1'b0} || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL midreset_first: got v=%b order=%0d intr=%b expected 1/0/0",
               rvfi_valid, rvfi_order, rvfi_intr);
    end
  endtask

  task automatic test_halt();
    rnd(1'b1, 1'b0, 1'b1);
    tick();
    vectors++;
    if (rvfi_valid !== 1'b1 || rvfi_halt !== 1'b1 || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL halt_record: got %h expected %h", w_obs, w_exp);
    end
    for (int i = 0; i < 4; i++) begin
      rnd(1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (rvfi_valid !== 1'b0 || w_obs !== w_exp) begin
        miscompares++;
        $display("FAIL halt_ignore%0d: got %h expected %h", i, w_obs, w_exp);
      end
    end
    g_resetn = 1'b0;
    tick();
    g_resetn = 1'b1;
    rnd(1'b1, 1'b1, 1'b1);
    tick();
    vectors++;
    if ({rvfi_valid, rvfi_trap, rvfi_halt} !== 3'b111 || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL trap_halt: got %h expected %h", w_obs, w_exp);
    end
    rnd(1'b1, 1'b0, 1'b0);
    tick();
    vectors++;
    if (rvfi_valid !== 1'b0 || w_obs !== w_exp) begin
      miscompares++;
      $display("FAIL trap_halt_after: got %h expected %h", w_obs, w_exp);
    end
  endtask

  initial begin
    g_resetn = 1'b0;
    rnd(1'b0, 1'b0, 1'b0);
    m_count = '0;
    m_after_trap = 1'b0;
    m_halted = 1'b0;
    test_reset();
    test_back_to_back();
    test_rd_zero();
    test_trap_intr();
    test_wrap();
    test_wide();
    test_random();
    test_reset_midstream();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frv_rvfi_trace.md
FRV_RVFI_TRACE -- requirements
Module: frv_rvfi_trace

Interface
REQ-001 Parameter: XLEN, default 32, datapath width of all register and PC trace fields.
REQ-002 g_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 g_resetn  input  1  reset, synchronous, active-low.
REQ-004 ret_valid  input  1  pipeline retires (or traps) one instruction this cycle.
REQ-005 ret_insn  input  32  retiring instruction word.
REQ-006 ret_pc / ret_npc  input  XLEN each  PC of the instruction / PC of the next instruction.
REQ-007 ret_trap  input  1  instruction raised an exception.
REQ-008 ret_rs1_addr, ret_rs2_addr, ret_rs3_addr, ret_rd_addr  input  5 each  register indices.
REQ-009 ret_rs1_data, ret_rs2_data, ret_rs3_data, ret_rd_data  input  XLEN each  operand values and writeback value.
REQ-010 ret_rd_wide  input  1  writeback is a 64-bit register pair; ret_rd_datahi  input  XLEN  high word.
REQ-011 ret_mem_addr, ret_mem_wdata  input  XLEN; ret_mem_rmask, ret_mem_wmask  input  XLEN/8  memory access record.
REQ-012 ret_halt  input  1  last instruction before halt.
REQ-013 Outputs rvfi_valid (1), rvfi_order (64), rvfi_insn (32), rvfi_trap, rvfi_halt, rvfi_intr (1 each), rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rs1/2/3_rdata, rvfi_rd_wdata, rvfi_rd_wdatahi, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata (XLEN each), rvfi_rs1/2/3_addr, rvfi_rd_addr (5 each), rvfi_rd_wide (1), rvfi_mem_rmask, rvfi_mem_wmask (XLEN/8 each), all registered.
REQ-014 ret_mem_rdata  input  XLEN  load data, captured with the record.

Function
REQ-015 Trace record SHALL appear on rvfi_* exactly one cycle after ret_valid is sampled high; rvfi_valid high for exactly that one cycle per retirement.
REQ-016 Cycles with ret_valid low SHALL drive rvfi_valid low; other rvfi_* fields SHALL hold previous values.
REQ-017 rvfi_order SHALL equal the count of records previously emitted since reset (first record 0), incrementing by 1 after each record, wrapping 2^64-1 -> 0.
REQ-018 rvfi_rd_wdata and rvfi_rd_wdatahi SHALL be zero when ret_rd_addr is 0, regardless of ret_rd_data.
REQ-019 rvfi_rd_wdatahi SHALL be zero when ret_rd_wide is low.
REQ-020 When ret_trap is high: rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_rmask, rvfi_mem_wmask SHALL be zero; rvfi_trap high.
REQ-021 State machine {RUN, TRAPPED, HALTED}: RUN->TRAPPED on record with trap; TRAPPED->RUN on next record; any->HALTED on record with ret_halt.
REQ-022 rvfi_intr SHALL be high on the first record emitted while in TRAPPED (first handler instruction), low otherwise.
REQ-023 In HALTED, ret_valid SHALL be ignored: rvfi_valid low, order frozen, until reset.
REQ-024 Simultaneous ret_trap and ret_halt: record emitted with both flags set; next state HALTED.

Reset
REQ-025 g_resetn low at a rising edge SHALL clear rvfi_valid, rvfi_order, all rvfi_* fields to zero and state to RUN; a retirement sampled in that cycle is discarded.
REQ-026 Reset mid-stream: first record after release carries rvfi_order 0 and rvfi_intr 0.

Configuration
REQ-027 Macro RVFI_WIDE_WRITEBACK_EN: defined -> rd_wide/rd_wdatahi traced per REQ-018/019; undefined -> rvfi_rd_wide and rvfi_rd_wdatahi constant zero, ret_rd_wide/ret_rd_datahi unused.

Verification
REQ-028 Reset, then 3 back-to-back ret_valid cycles -> rvfi_valid high on cycles 1..3 with rvfi_order 0,1,2.
REQ-029 ret_rd_addr=0, ret_rd_data=32'hDEADBEEF -> rvfi_rd_wdata=0; ret_rd_addr=5 same data -> 32'hDEADBEEF.
REQ-030 Record with ret_trap=1, ret_mem_wmask=4'hF -> rvfi_trap=1, wmask=0; next record -> rvfi_intr=1; following record -> rvfi_intr=0.
REQ-031 Record with ret_halt=1, then 4 more ret_valid pulses -> only halt record emitted, rvfi_order unchanged.
REQ-032 Force order to 2^64-1 (via preload in bench) and retire twice -> orders 2^64-1 then 0.
REQ-033 With macro defined, ret_rd_wide=1, rd=6, datahi=32'h12345678 -> rvfi_rd_wdatahi=32'h12345678; undefined -> 0.
